// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR widths, gain shift, warm-up length and saturation limit
package fir_pkg;

    localparam int FIR_IN_W   = 18;
    localparam int FIR_SHIFT  = 8;
    localparam int FIR_OUT_W  = 8;
    // The FIR holds 8 samples in its delay line before the first result is
    // meaningful, so that many leading results are discarded.
    localparam int FIR_WARMUP = 8;
    localparam int FIR_SAT_MAX = (1 << FIR_OUT_W) - 1;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with level, full and empty flags
//
// Ports:
//   clk, rst_n_i      clock, asynchronous active-low reset
//   flush_i           synchronous clear, wins over push and pop
//   push_i, data_i    write request and data; refused when full unless a pop
//                     happens in the same cycle
//   pop_i             read request; ignored when empty
//   data_o            head entry; holds the last popped value while empty
//   level_o           occupancy
//   full_o, empty_o   status flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             do_pop;
    logic             do_push;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign level_o = cnt_q;
    // hold_q keeps the most recently popped value so the output is stable once drained
    assign data_o  = empty_o ? hold_q : mem[rd_q];

    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        hold_d = hold_q;
        if (flush_i) begin
            wr_d   = '0;
            rd_d   = '0;
            cnt_d  = '0;
            hold_d = '0;
        end else begin
            if (do_push) begin
                wr_d = wr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_d   = rd_q + PTR_W'(1);
                hold_d = mem[rd_q];
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
                2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            hold_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            hold_q <= hold_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/fir_out_decimator.sv
// rtl/fir_out_decimator.sv - FIR output rescale, saturate, warm-up discard, decimate and buffer
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   din, din_valid        unsigned FIR result and its strobe
//   flush                 synchronous clear of all state, wins over din_valid
//   dout, dout_valid      FIFO head and not-empty flag
//   dout_ready            consumer accepts dout this cycle
//   level                 FIFO occupancy
//   overflow              sticky: a kept sample was dropped at full FIFO
module fir_out_decimator
    import fir_pkg::*;
#(
    parameter int IN_W   = FIR_IN_W,
    parameter int OUT_W  = FIR_OUT_W,
    parameter int SHIFT  = FIR_SHIFT,
    parameter int DECIM  = 4,
    parameter int WARMUP = FIR_WARMUP,
    parameter int DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [IN_W-1:0]        din,
    input  logic                   din_valid,
    input  logic                   flush,
    output logic [OUT_W-1:0]       dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    localparam int CNT_W = $clog2(WARMUP + 1);
    localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int R_W   = IN_W + 1 - SHIFT;
    localparam logic [IN_W:0]  HALF  = (IN_W+1)'(1) << (SHIFT - 1);
    localparam logic [R_W-1:0] SAT_R = R_W'((1 << OUT_W) - 1);

    logic [CNT_W-1:0] warm_q, warm_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic             stage_vld_q, stage_vld_d;
    logic [OUT_W-1:0] stage_data_q, stage_data_d;
    logic             overflow_q, overflow_d;
    logic [R_W-1:0]   rounded;
    logic [OUT_W-1:0] scaled;
    logic             warm_done;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop_now;

    // One extra bit of headroom so adding the half-LSB cannot wrap.
    assign rounded   = R_W'(({1'b0, din} + HALF) >> SHIFT);
    assign scaled    = (rounded > SAT_R) ? {OUT_W{1'b1}} : rounded[OUT_W-1:0];
    assign warm_done = (warm_q == CNT_W'(WARMUP));

    always_comb begin
        warm_d       = warm_q;
        phase_d      = phase_q;
        stage_vld_d  = 1'b0;
        stage_data_d = stage_data_q;
        if (flush) begin
            warm_d  = '0;
            phase_d = '0;
        end else if (din_valid) begin
            if (!warm_done) begin
                warm_d = warm_q + CNT_W'(1);
            end else begin
                if (phase_q == '0) begin
                    stage_vld_d  = 1'b1;
                    stage_data_d = scaled;
                end
                phase_d = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + PH_W'(1);
            end
        end
    end

    // A staged sample is lost only when the FIFO is full and nothing leaves it this cycle.
    assign pop_now = dout_valid && dout_ready;

    always_comb begin
        overflow_d = overflow_q;
        if (flush) begin
            overflow_d = 1'b0;
        end else if (stage_vld_q && fifo_full && !pop_now) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            warm_q       <= '0;
            phase_q      <= '0;
            stage_vld_q  <= 1'b0;
            stage_data_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            warm_q       <= warm_d;
            phase_q      <= phase_d;
            stage_vld_q  <= stage_vld_d;
            stage_data_q <= stage_data_d;
            overflow_q   <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n_i (reset),
        .flush_i (flush),
        .push_i  (stage_vld_q),
        .data_i  (stage_data_q),
        .pop_i   (dout_ready),
        .data_o  (dout),
        .level_o (level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign dout_valid = !fifo_empty;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_fir_out_decimator.sv
// tb/tb_fir_out_decimator.sv - directed self-checking bench for fir_out_decimator
module tb_fir_out_decimator;

    logic        clk = 1'b0;
    logic        reset;
    logic [17:0] din;
    logic        din_valid;
    logic        flush;
    logic        dout_ready;

    logic [7:0]  dout1, dout4;
    logic        dv1, dv4;
    logic [3:0]  lvl1, lvl4;
    logic        ovf1, ovf4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fir_out_decimator #(.DECIM(1)) u_d1 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .flush(flush),
        .dout(dout1), .dout_valid(dv1), .dout_ready(dout_ready), .level(lvl1), .overflow(ovf1)
    );

    fir_out_decimator #(.DECIM(4)) u_d4 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .flush(flush),
        .dout(dout4), .dout_valid(dv4), .dout_ready(dout_ready), .level(lvl4), .overflow(ovf4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input int v);
        @(negedge clk);
        din       = 18'(v);
        din_valid = 1'b1;
    endtask

    task automatic settle();
        @(negedge clk);
        din_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic warmup();
        repeat (8) send(0);
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush      = 1'b1;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic pop_check(input string tag, input int exp);
        check_eq({tag, "_valid"}, 32'(dv1), 1);
        check_eq(tag, 32'(dout1), 32'(exp));
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
    endtask

    int got4[$];

    initial begin
        reset = 1'b0; din = '0; din_valid = 1'b0; flush = 1'b0; dout_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_dout", 32'(dout1), 0);
        check_eq("rst_valid", 32'(dv1), 0);
        check_eq("rst_level", 32'(lvl1), 0);
        check_eq("rst_ovf", 32'(ovf1), 0);
        reset = 1'b1;

        // Warm-up and latency
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("warm_valid", 32'(dv1), 0);
            din = 18'd1000; din_valid = 1'b1;
        end
        @(negedge clk);
        check_eq("warm_valid_end", 32'(dv1), 0);
        din = 18'd25600;
        @(negedge clk);
        din_valid = 1'b0;
        check_eq("lat_t1_valid", 32'(dv1), 0);
        @(negedge clk);
        check_eq("lat_t2_valid", 32'(dv1), 1);
        check_eq("lat_t2_dout", 32'(dout1), 100);
        check_eq("lat_t2_level", 32'(lvl1), 1);
        check_eq("lat_d4_dout", 32'(dout4), 100);

        // Rounding
        do_flush();
        warmup();
        send(383); send(384); send(127); send(128);
        settle();
        pop_check("round_383", 1);
        pop_check("round_384", 2);
        pop_check("round_127", 0);
        pop_check("round_128", 1);
        check_eq("round_level", 32'(lvl1), 0);
        check_eq("round_hold", 32'(dout1), 1);

        // Saturation
        do_flush();
        warmup();
        send(67065); send(262143); send(65280);
        settle();
        pop_check("sat_67065", 255);
        pop_check("sat_262143", 255);
        pop_check("sat_65280", 255);
        check_eq("sat_ovf", 32'(ovf1), 0);

        // Decimation by 4
        do_flush();
        warmup();
        dout_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (dv4) got4.push_back(int'(dout4));
            check_eq("dec_level_le1", 32'(lvl4 <= 4'd1), 1);
            din       = 18'(256 * k);
            din_valid = (k < 12);
        end
        dout_ready = 1'b0;
        check_eq("dec_count", 32'(got4.size()), 3);
        for (int i = 0; i < 3; i++) begin
            check_eq("dec_value", (i < got4.size()) ? 32'(got4[i]) : 32'hDEAD, 32'(4 * i));
        end

        // Overflow and drain
        do_flush();
        warmup();
        for (int v = 10; v <= 18; v++) send(256 * v);
        settle();
        check_eq("ovf_level", 32'(lvl1), 8);
        check_eq("ovf_flag", 32'(ovf1), 1);
        for (int v = 10; v <= 17; v++) pop_check("ovf_drain", v);
        check_eq("ovf_drain_level", 32'(lvl1), 0);
        check_eq("ovf_drain_valid", 32'(dv1), 0);
        check_eq("ovf_sticky", 32'(ovf1), 1);

        // Full with simultaneous pop
        do_flush();
        check_eq("flush_ovf", 32'(ovf1), 0);
        check_eq("flush_level", 32'(lvl1), 0);
        warmup();
        for (int v = 20; v <= 27; v++) send(256 * v);
        send(256 * 28);
        @(negedge clk);
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
        check_eq("fullpop_level", 32'(lvl1), 8);
        check_eq("fullpop_ovf", 32'(ovf1), 0);
        for (int v = 21; v <= 28; v++) pop_check("fullpop_drain", v);
        check_eq("fullpop_empty", 32'(lvl1), 0);

        // Flush restarts warm-up
        do_flush();
        repeat (8) send(256 * 50);
        settle();
        check_eq("rewarm_level", 32'(lvl1), 0);
        check_eq("rewarm_valid", 32'(dv1), 0);
        send(256 * 60);
        settle();
        check_eq("rewarm_first", 32'(dout1), 60);
        check_eq("rewarm_first_valid", 32'(dv1), 1);
        check_eq("rewarm_d4_first", 32'(dout4), 60);

        // Asynchronous reset mid-stream
        send(256 * 61);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst_valid", 32'(dv1), 0);
        check_eq("arst_level", 32'(lvl1), 0);
        check_eq("arst_d4_level", 32'(lvl4), 0);
        din_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("post_rst_valid", 32'(dv1), 0);
        check_eq("post_rst_dout", 32'(dout1), 0);
        check_eq("post_rst_ovf", 32'(ovf1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
